// File: rtl/spi_master_ctrl.sv
// SPI master for the SPI slave + RAM wrapper: one SS_n frame per RAM command, read bytes returned.
// Define SPIM_CMD_BUF_EN to add a 1-entry command buffer that launches frames back to back.
module spi_master_ctrl #(
   parameter int unsigned RD_LAT = 4,
   parameter int unsigned GAP    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       seq_err
);

   localparam int unsigned CntMax = (RD_LAT > GAP) ? ((RD_LAT > 9) ? RD_LAT : 9)
                                                   : ((GAP > 9) ? GAP : 9);
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   typedef enum logic [2:0] {StIdle, StSel, StCmd, StShift, StWait, StCapt, StGap} state_e;

   state_e          state;
   logic [CntW-1:0] cnt;
   logic [9:0]      frame;
   logic [7:0]      shreg;
   logic            rd_pend;
   logic            rsp_pend;
   logic            err_pend;
   logic            gap_done;
   logic            launch;
   logic            illegal;
   logic [1:0]      l_type;
   logic [7:0]      l_data;

`ifdef SPIM_CMD_BUF_EN
   logic            buf_valid;
   logic [1:0]      buf_type;
   logic [7:0]      buf_data;
`endif

   always_comb begin
      gap_done = (state == StGap) && (cnt == '0);
`ifdef SPIM_CMD_BUF_EN
      launch   = buf_valid && ((state == StIdle) || gap_done);
      l_type   = buf_type;
      l_data   = buf_data;
`else
      launch   = cmd_valid && cmd_ready && (state == StIdle);
      l_type   = cmd_type;
      l_data   = cmd_data;
`endif
      // Mirrors the slave's addr-received flag: rd-data needs a prior rd-addr, and vice versa.
      illegal  = ((l_type == 2'b11) && !rd_pend) || ((l_type == 2'b10) && rd_pend);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         cnt       <= '0;
         frame     <= '0;
         shreg     <= '0;
         rd_pend   <= 1'b0;
         rsp_pend  <= 1'b0;
         err_pend  <= 1'b0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         seq_err   <= 1'b0;
`ifdef SPIM_CMD_BUF_EN
         buf_valid <= 1'b0;
         buf_type  <= '0;
         buf_data  <= '0;
`endif
      end else begin
         rsp_valid <= rsp_pend;
         rsp_pend  <= 1'b0;
         seq_err   <= err_pend;
         err_pend  <= 1'b0;
         if (rsp_pend) begin
            rsp_data <= shreg;
         end

         unique case (state)
            StIdle: ;
            StSel: begin
               MOSI  <= frame[9];
               state <= StCmd;
            end
            StCmd: begin
               MOSI  <= frame[9];
               cnt   <= CntW'(9);
               state <= StShift;
            end
            StShift: begin
               if (cnt != '0) begin
                  MOSI <= frame[cnt - 1'b1];
                  cnt  <= cnt - 1'b1;
               end else if (frame[9:8] == 2'b11) begin
                  if (RD_LAT > 1) begin
                     state <= StWait;
                     cnt   <= CntW'(RD_LAT - 1);
                  end else begin
                     state <= StCapt;
                     cnt   <= CntW'(7);
                  end
               end else begin
                  SS_n  <= 1'b1;
                  state <= StGap;
                  cnt   <= CntW'(GAP - 1);
                  if (frame[9:8] == 2'b10) begin
                     rd_pend <= 1'b1;
                  end
               end
            end
            StWait: begin
               if (cnt == CntW'(1)) begin
                  state <= StCapt;
                  cnt   <= CntW'(7);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StCapt: begin
               shreg <= {shreg[6:0], MISO};
               if (cnt == '0) begin
                  SS_n     <= 1'b1;
                  rd_pend  <= 1'b0;
                  rsp_pend <= 1'b1;
                  state    <= StGap;
                  cnt      <= CntW'(GAP - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            StGap: begin
               if (gap_done) begin
                  state <= StIdle;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= StIdle;
         endcase

         // A launch overrides the state chosen above (only possible in idle or on gap exit).
         if (launch) begin
            if (illegal) begin
               err_pend <= 1'b1;
               state    <= StIdle;
            end else begin
               SS_n  <= 1'b0;
               frame <= {l_type, l_data};
               state <= StSel;
            end
         end

`ifdef SPIM_CMD_BUF_EN
         if (cmd_valid && cmd_ready) begin
            buf_valid <= 1'b1;
            buf_type  <= cmd_type;
            buf_data  <= cmd_data;
         end else if (launch) begin
            buf_valid <= 1'b0;
         end
         cmd_ready <= !((cmd_valid && cmd_ready) || (buf_valid && !launch));
`else
         cmd_ready <= ((state == StIdle) || gap_done) && !(launch && !illegal);
`endif
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave + RAM on the serial side.
module tb_spi_master_ctrl;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_type  = 2'b00;
   logic [7:0] cmd_data  = 8'h00;
   logic       SS_n;
   logic       MOSI;
   logic       MISO      = 1'b0;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       seq_err;

   int n_cmp  = 0;
   int n_fail = 0;

   spi_master_ctrl #(
      .RD_LAT(4),
      .GAP   (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_type (cmd_type),
      .cmd_data (cmd_data),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .seq_err  (seq_err)
   );

   always #5 clk = ~clk;

   // Slave model, evaluated on the falling edge; j counts falling edges since SS_n fell.
   logic [7:0] mem [256];
   logic [7:0] s_waddr = 8'h00;
   logic [7:0] s_raddr = 8'h00;
   logic [7:0] s_byte  = 8'h00;
   logic [7:0] s_out   = 8'h00;
   logic [9:0] s_sh    = 10'h000;
   logic [9:0] s_rx    = 10'h000;
   int         s_j     = 0;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         s_waddr = 8'h00;
         s_raddr = 8'h00;
      end
      if (SS_n !== 1'b0) begin
         s_j = 0;
      end else begin
         if (s_j >= 2 && s_j <= 11) s_sh = {s_sh[8:0], MOSI};
         if (s_j == 11) begin
            s_rx = s_sh;
            case (s_sh[9:8])
               2'b00: s_waddr = s_sh[7:0];
               2'b01: mem[s_waddr] = s_sh[7:0];
               2'b10: s_raddr = s_sh[7:0];
               default: s_byte = mem[s_raddr];
            endcase
         end
         if (s_j == 15) begin
            s_out = s_byte;
            MISO  = s_out[7];
         end
         if (s_j >= 16 && s_j <= 22) begin
            s_out = {s_out[6:0], 1'b0};
            MISO  = s_out[7];
         end
         s_j++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle;
      int run = 0;
      for (int i = 0; i < 400 && run < 16; i++) begin
         @(negedge clk);
         if (SS_n === 1'b1) run++;
         else run = 0;
      end
      n_cmp++;
      if (run !== 16) begin
         n_fail++;
         $display("FAIL wait_idle: SS_n high run %0d, required 16", run);
      end
   endtask

   // Returns #1 after the edge on which the command launches.
   task automatic send_cmd(input logic [1:0] t, input logic [7:0] d);
      bit ok = 1'b0;
      wait_idle();
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_data  = d;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: cmd_ready stayed %b, required 1", cmd_ready);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         cmd_valid = 1'b0;
`ifdef SPIM_CMD_BUF_EN
         @(posedge clk);
         #1;
`endif
      end
   endtask

   task automatic wait_rsp(output int lat, output logic [7:0] d, output int pulses);
      lat    = -1;
      d      = 8'h00;
      pulses = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (rsp_valid === 1'b1) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               d   = rsp_data;
            end
         end
      end
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      tick();
      tick();
      n_cmp++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL rst_ss_n: got %b want 1", SS_n); end
      n_cmp++; if (MOSI !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
      n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
      n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      n_cmp++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
      n_cmp++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL rst_seq_err: got %b want 0", seq_err); end
      // cmd_valid together with rst must be ignored
      cmd_valid = 1'b1;
      cmd_type  = 2'b00;
      cmd_data  = 8'h11;
      tick();
      rst       = 1'b0;
      cmd_valid = 1'b0;
      n_cmp++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL rst_vs_valid_ss: got %b want 1", SS_n); end
      tick();
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", cmd_ready); end
      n_cmp++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL post_rst_ss: got %b want 1", SS_n); end
   endtask

   task automatic test_frame;
      logic [10:0] exp_bits = 11'b0_00_0011_1010;
      send_cmd(2'b00, 8'h3A);
      n_cmp++; if (SS_n !== 1'b0) begin n_fail++; $display("FAIL frame_ss_at_A: got %b want 0", SS_n); end
      for (int k = 1; k <= 11; k++) begin
         tick();
         n_cmp++;
         if ({SS_n, MOSI} !== {1'b0, exp_bits[11-k]}) begin
            n_fail++;
            $display("FAIL frame_bit_A+%0d: got ss=%b mosi=%b want ss=0 mosi=%b", k, SS_n, MOSI,
                     exp_bits[11-k]);
         end
      end
      tick();
      n_cmp++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL frame_ss_at_A+12: got %b want 1", SS_n); end
      n_cmp++; if (s_rx !== 10'h03A) begin n_fail++; $display("FAIL frame_slave_rx: got %h want 03a", s_rx); end
   endtask

   task automatic test_read;
      logic ss22 = 1'bx;
      logic ss23 = 1'bx;
      int   lat  = -1;
      int   pulses = 0;
      logic [7:0] d = 8'h00;
      send_cmd(2'b00, 8'h3A);
      send_cmd(2'b01, 8'hC5);
      send_cmd(2'b10, 8'h3A);
      send_cmd(2'b11, 8'h00);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 22) ss22 = SS_n;
         if (k == 23) ss23 = SS_n;
         if (rsp_valid === 1'b1) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               d   = rsp_data;
            end
         end
      end
      n_cmp++; if (ss22 !== 1'b0) begin n_fail++; $display("FAIL read_ss_A+22: got %b want 0", ss22); end
      n_cmp++; if (ss23 !== 1'b1) begin n_fail++; $display("FAIL read_ss_A+23: got %b want 1", ss23); end
      n_cmp++; if (lat !== 24) begin n_fail++; $display("FAIL read_rsp_latency: got %0d want 24", lat); end
      n_cmp++; if (d !== 8'hC5) begin n_fail++; $display("FAIL read_rsp_data: got %h want c5", d); end
      n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL read_rsp_pulses: got %0d want 1", pulses); end
      // rd_pend must be clear again: another rd-data is rejected
      send_cmd(2'b11, 8'h00);
      n_cmp++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL read_clear_err_A: got %b want 0", seq_err); end
      tick();
      n_cmp++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL read_clear_err_A+1: got %b want 1", seq_err); end
      n_cmp++; if (rsp_data !== 8'hC5) begin n_fail++; $display("FAIL read_rsp_held: got %h want c5", rsp_data); end
   endtask

   task automatic test_seq_err;
      int lows = 0;
      int rsps = 0;
      apply_reset();
      send_cmd(2'b11, 8'h00);
      n_cmp++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL seq_ss_at_A: got %b want 1", SS_n); end
      tick();
      n_cmp++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_err_A+1: got %b want 1", seq_err); end
      tick();
      n_cmp++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_err_A+2: got %b want 0", seq_err); end
      for (int k = 0; k < 30; k++) begin
         tick();
         if (SS_n !== 1'b1) lows++;
         if (rsp_valid !== 1'b0) rsps++;
      end
      n_cmp++; if (lows !== 0) begin n_fail++; $display("FAIL seq_no_frame: got %0d low cycles want 0", lows); end
      n_cmp++; if (rsps !== 0) begin n_fail++; $display("FAIL seq_no_rsp: got %0d pulses want 0", rsps); end
      send_cmd(2'b10, 8'h3A);
      tick();
      n_cmp++; if ({seq_err, SS_n} !== 2'b00) begin n_fail++; $display("FAIL seq_first_rd_addr: got err=%b ss=%b want err=0 ss=0", seq_err, SS_n); end
      send_cmd(2'b10, 8'h3A);
      tick();
      n_cmp++; if ({seq_err, SS_n} !== 2'b11) begin n_fail++; $display("FAIL seq_second_rd_addr: got err=%b ss=%b want err=1 ss=1", seq_err, SS_n); end
   endtask

   task automatic test_reset_mid;
      int rsps = 0;
      int lat = -1;
      int pulses = 0;
      logic [7:0] d = 8'h00;
      apply_reset();
      send_cmd(2'b10, 8'h55);
      for (int k = 0; k < 5; k++) tick();
      rst = 1'b1;
      tick();
      n_cmp++; if (SS_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ss: got %b want 1", SS_n); end
      n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", cmd_ready); end
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (rsp_valid !== 1'b0) rsps++;
      end
      n_cmp++; if (rsps !== 0) begin n_fail++; $display("FAIL mid_rst_no_rsp: got %0d pulses want 0", rsps); end
      send_cmd(2'b11, 8'h00);
      tick();
      n_cmp++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rd_pend: got seq_err=%b want 1", seq_err); end
      send_cmd(2'b00, 8'h55);
      send_cmd(2'b01, 8'h9E);
      send_cmd(2'b10, 8'h55);
      send_cmd(2'b11, 8'h00);
      wait_rsp(lat, d, pulses);
      n_cmp++; if (lat !== 24) begin n_fail++; $display("FAIL mid_rst_latency: got %0d want 24", lat); end
      n_cmp++; if (d !== 8'h9E) begin n_fail++; $display("FAIL mid_rst_data: got %h want 9e", d); end
   endtask

   task automatic test_sweep;
      logic [7:0] addrs [4] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
      logic [7:0] datas [4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
      int lat = -1;
      int pulses = 0;
      logic [7:0] d = 8'h00;
      for (int i = 0; i < 4; i++) begin
         send_cmd(2'b00, addrs[i]);
         send_cmd(2'b01, datas[i]);
         send_cmd(2'b10, addrs[i]);
         send_cmd(2'b11, 8'h00);
         wait_rsp(lat, d, pulses);
         n_cmp++;
         if ({lat == 24, d} !== {1'b1, datas[i]}) begin
            n_fail++;
            $display("FAIL sweep_%0d addr %h: got lat=%0d data=%h want lat=24 data=%h", i, addrs[i],
                     lat, d, datas[i]);
         end
      end
   endtask

`ifdef SPIM_CMD_BUF_EN
   task automatic test_back_to_back;
      logic [1:0] types [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [7:0] datas [4] = '{8'h12, 8'h6B, 8'h12, 8'h00};
      int gaps [3] = '{0, 0, 0};
      int ng = 0;
      int high_run = 0;
      bit seen_low = 1'b0;
      int nrsp = 0;
      logic [7:0] rsp = 8'h00;
      wait_idle();
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               bit ok = 1'b0;
               cmd_valid = 1'b1;
               cmd_type  = types[i];
               cmd_data  = datas[i];
               for (int j = 0; j < 100; j++) begin
                  if (cmd_ready === 1'b1) begin
                     ok = 1'b1;
                     break;
                  end
                  @(negedge clk);
               end
               if (!ok) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL b2b_accept_%0d: cmd_ready stayed %b, required 1", i, cmd_ready);
               end
               @(posedge clk);
               #1;
            end
            cmd_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 150; k++) begin
               tick();
               if (SS_n === 1'b1) begin
                  high_run++;
               end else begin
                  if (seen_low && high_run > 0 && ng < 3) begin
                     gaps[ng] = high_run;
                     ng++;
                  end
                  seen_low = 1'b1;
                  high_run = 0;
               end
               if (rsp_valid === 1'b1) begin
                  nrsp++;
                  rsp = rsp_data;
               end
            end
         end
      join
      n_cmp++; if (ng !== 3) begin n_fail++; $display("FAIL b2b_gap_count: got %0d want 3", ng); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (gaps[i] !== 2) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d want 2", i, gaps[i]); end
      end
      n_cmp++; if ({nrsp, rsp} !== {32'd1, 8'h6B}) begin n_fail++; $display("FAIL b2b_rsp: got n=%0d data=%h want n=1 data=6b", nrsp, rsp); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_read();
      test_seq_err();
      test_reset_mid();
      test_sweep();
`ifdef SPIM_CMD_BUF_EN
      test_back_to_back();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
